// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard/stall controller for the 5-stage pipeline.
// It arbitrates the shared memory port between instruction fetch and data
// access, tracks fetches squashed by an EX jump, and drives the thermometer
// stall vector used by every stage register.
module stall_ctrl #(
  parameter int PIPE_NUM = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic                if_done,
  input  logic                mem_req,
  input  logic                mem_done,
  input  logic                id_stall_req,
  input  logic                jump_i,
  output logic                if_grant,
  output logic                mem_grant,
  output logic                if_discard,
  output logic [PIPE_NUM-1:0] stall_o
);

  // Stall patterns. A stalled stage holds itself and every stage upstream
  // of it, so each pattern is a run of contiguous low bits.
  localparam logic [PIPE_NUM-1:0] C_STALL_MEM = PIPE_NUM'((1 << 5) - 1);
  localparam logic [PIPE_NUM-1:0] C_STALL_ID  = PIPE_NUM'((1 << 3) - 1);
  localparam logic [PIPE_NUM-1:0] C_STALL_IF  = PIPE_NUM'((1 << 2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_MEM_BUSY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_discard;
  logic                w_discard_nxt;

  // A done pulse counts only while its grant is held.
  logic                w_if_fire;
  logic                w_mem_fire;
  logic                w_if_discard;
  logic                w_s_if;
  logic                w_s_id;
  logic                w_s_mem;
  logic [PIPE_NUM-1:0] w_stall;

  // Grants come straight from the state register, so they are glitch-free.
  assign if_grant  = (r_state == ST_IF_BUSY);
  assign mem_grant = (r_state == ST_MEM_BUSY);

  assign w_if_fire  = if_done  & if_grant;
  assign w_mem_fire = mem_done & mem_grant;

  // A returning word is stale if a jump already squashed it, or if the jump
  // arrives in the very cycle the word comes back.
  assign w_if_discard = w_if_fire & (r_discard | jump_i);

  // A discarded fetch leaves the IF request unserved, so IF keeps stalling
  // and re-requests at the redirected PC.
  assign w_s_if  = if_req  & ~(w_if_fire & ~w_if_discard);
  assign w_s_id  = id_stall_req;
  assign w_s_mem = mem_req & ~w_mem_fire;

  // State and squash flag; reset abandons any transfer in flight.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // Port arbitration: MEM wins ties in IDLE, nothing preempts a transfer.
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for w_state_nxt.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (mem_req) begin
          w_state_nxt = ST_MEM_BUSY;
        end else if (if_req) begin
          w_state_nxt = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY: begin
        if (if_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MEM_BUSY: begin
        if (mem_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Squash tracking: only a jump during an in-flight fetch that is not
  // returning this cycle marks the pending word as stale.
  always_comb begin
    w_discard_nxt = r_discard;
    if (r_state == ST_IF_BUSY) begin
      if (if_done) begin
        w_discard_nxt = 1'b0;
      end else if (jump_i) begin
        w_discard_nxt = 1'b1;
      end
    end
  end

  // Stall priority: deepest requesting stage wins.
  always_comb begin
    w_stall = '0;
    if (w_s_mem) begin
      w_stall = C_STALL_MEM;
    end else if (w_s_id) begin
      w_stall = C_STALL_ID;
    end else if (w_s_if) begin
      w_stall = C_STALL_IF;
    end
  end

  assign if_discard = w_if_discard;
  assign stall_o    = w_stall;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed scenarios with literal expectations, then random
// protocol-legal traffic, all checked every cycle against a behavioural
// model of who owns the memory port and whether the pending fetch is stale.
module tb_stall_ctrl;

  localparam int PIPE_NUM = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                if_req = 1'b0;
  logic                if_done = 1'b0;
  logic                mem_req = 1'b0;
  logic                mem_done = 1'b0;
  logic                id_stall_req = 1'b0;
  logic                jump_i = 1'b0;
  logic                if_grant;
  logic                mem_grant;
  logic                if_discard;
  logic [PIPE_NUM-1:0] stall_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: owner of the port (0 none, 1 fetch, 2 data) and stale flag.
  int m_owner = 0;
  bit m_stale = 1'b0;

  stall_ctrl #(.PIPE_NUM(PIPE_NUM)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_done      (if_done),
    .mem_req      (mem_req),
    .mem_done     (mem_done),
    .id_stall_req (id_stall_req),
    .jump_i       (jump_i),
    .if_grant     (if_grant),
    .mem_grant    (mem_grant),
    .if_discard   (if_discard),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stall vector from how many stage registers must hold.
  function automatic logic [PIPE_NUM-1:0] hold_low(input int depth);
    logic [PIPE_NUM-1:0] v;
    v = '0;
    for (int i = 0; i < depth; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit exp_discard();
    return if_done && (m_owner == 1) && (m_stale || jump_i);
  endfunction

  function automatic bit fetch_served();
    return if_done && (m_owner == 1) && !exp_discard();
  endfunction

  function automatic bit data_served();
    return mem_done && (m_owner == 2);
  endfunction

  function automatic logic [PIPE_NUM-1:0] exp_stall();
    int depth;
    depth = 0;
    if (mem_req && !data_served())       depth = 5;
    else if (id_stall_req)               depth = 3;
    else if (if_req && !fetch_served())  depth = 2;
    return hold_low(depth);
  endfunction

  // Model advance on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0;
      m_stale = 1'b0;
    end else if (m_owner == 0) begin
      if (mem_req)     m_owner = 2;
      else if (if_req) m_owner = 1;
    end else if (m_owner == 1) begin
      if (if_done) begin
        m_owner = 0;
        m_stale = 1'b0;
      end else if (jump_i) begin
        m_stale = 1'b1;
      end
    end else if (mem_done) begin
      m_owner = 0;
    end
  end

  // Compare process: outputs against the model, mid low phase.
  always @(negedge clk) begin
    #2;
    if (chk_en && !rst) begin
      check("m_if_grant",   {31'd0, if_grant},   {31'd0, m_owner == 1});
      check("m_mem_grant",  {31'd0, mem_grant},  {31'd0, m_owner == 2});
      check("m_if_discard", {31'd0, if_discard}, {31'd0, exp_discard()});
      check("m_stall",      {26'd0, stall_o},    {26'd0, exp_stall()});
    end
  end

  // One cycle of stimulus: inputs change on the falling edge.
  task automatic cyc(input bit r, input bit ir, input bit idn, input bit mr,
                     input bit md, input bit isr, input bit j);
    @(negedge clk);
    rst = r; if_req = ir; if_done = idn; mem_req = mr;
    mem_done = md; id_stall_req = isr; jump_i = j;
    #3;
  endtask

  task automatic lit(input string name, input bit ig, input bit mg, input bit dc,
                     input logic [PIPE_NUM-1:0] st);
    check({name, "_ifg"},  {31'd0, if_grant},   {31'd0, ig});
    check({name, "_memg"}, {31'd0, mem_grant},  {31'd0, mg});
    check({name, "_disc"}, {31'd0, if_discard}, {31'd0, dc});
    check({name, "_stall"}, {26'd0, stall_o},   {26'd0, st});
  endtask

  initial begin
    bit ir, mr, idn, md, isr, j, r;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    //              r ir idn mr md isr j
    cyc(0, 0, 0, 0, 0, 0, 0); lit("reset", 0, 0, 0, 6'b000000);

    // Plain fetch, done at t3.
    cyc(0, 1, 0, 0, 0, 0, 0); lit("f_t0", 0, 0, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("f_t1", 1, 0, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("f_t2", 1, 0, 0, 6'b000011);
    cyc(0, 1, 1, 0, 0, 0, 0); lit("f_t3", 1, 0, 0, 6'b000000);
    cyc(0, 0, 0, 0, 0, 0, 0); lit("f_t4", 0, 0, 0, 6'b000000);

    // MEM wins a tie, IF follows after an IDLE cycle.
    cyc(0, 1, 0, 1, 0, 0, 0); lit("a_t0", 0, 0, 0, 6'b011111);
    cyc(0, 1, 0, 1, 0, 0, 0); lit("a_t1", 0, 1, 0, 6'b011111);
    cyc(0, 1, 0, 1, 1, 0, 0); lit("a_t2", 0, 1, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("a_t3", 0, 0, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("a_t4", 1, 0, 0, 6'b000011);
    cyc(0, 1, 1, 0, 0, 0, 0); lit("a_t5", 1, 0, 0, 6'b000000);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Jump during fetch: returned word discarded, retry is clean.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("d_t1", 1, 0, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 1); lit("d_t2", 1, 0, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("d_t3", 1, 0, 0, 6'b000011);
    cyc(0, 1, 1, 0, 0, 0, 0); lit("d_t4", 1, 0, 1, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("d_t5", 0, 0, 0, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("d_t6", 1, 0, 0, 6'b000011);
    cyc(0, 1, 1, 0, 0, 0, 0); lit("d_t7", 1, 0, 0, 6'b000000);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Jump coincident with done: discarded now, nothing left pending.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 1); lit("c_t2", 1, 0, 1, 6'b000011);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0); lit("c_t4", 1, 0, 0, 6'b000011);
    cyc(0, 1, 1, 0, 0, 0, 0); lit("c_t5", 1, 0, 0, 6'b000000);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Load-use bubble, alone and under a MEM stall; jump under MEM stall.
    cyc(0, 0, 0, 0, 0, 1, 0); lit("id_1", 0, 0, 0, 6'b000111);
    cyc(0, 0, 0, 0, 0, 0, 0); lit("id_0", 0, 0, 0, 6'b000000);
    cyc(0, 0, 0, 1, 0, 1, 0); lit("idm",  0, 0, 0, 6'b011111);
    cyc(0, 0, 0, 1, 0, 0, 1); lit("jm",   0, 1, 0, 6'b011111);

    // Reset while MEM_BUSY abandons the transfer; late done ignored.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); lit("rst_m", 0, 0, 0, 6'b000000);
    cyc(0, 0, 1, 0, 0, 0, 0); lit("spur",  0, 0, 0, 6'b000000);

    // Random protocol-legal traffic.
    ir = 0; mr = 0;
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom % 250) == 0;
      if (r) begin
        ir = 0; mr = 0; idn = 0; md = 0; isr = 0; j = 0;
      end else begin
        if (!ir && ($urandom % 4) == 0) ir = 1;
        if (!mr && ($urandom % 6) == 0) mr = 1;
        idn = (m_owner == 1) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
        md  = (m_owner == 2) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
        isr = ($urandom % 6) == 0;
        j   = ($urandom % 7) == 0;
      end
      cyc(r, ir, idn, mr, md, isr, j);
      if (!r) begin
        if (fetch_served()) ir = 0;
        if (data_served())  mr = 0;
      end
    end

    cyc(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage RISC-V pipeline. Drives the stall vector consumed by every stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates the single shared memory port between instruction fetch (IF) and data access (MEM).
- Tracks fetches squashed by an EX jump, so a stale instruction delivered after a redirect is discarded rather than issued.

Parameters:
- PIPE_NUM, 6, stall vector width. Bit 0 = PC, 1 = IF/if_id, 2 = ID/id_ex, 3 = EX/ex_mem, 4 = MEM/mem_wb, 5 = WB.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF needs an instruction word; level, held until served
- if_done  in  1  memory returns IF word this cycle; single-cycle pulse
- mem_req  in  1  MEM stage needs a load/store; level, held until served
- mem_done  in  1  memory completes MEM access this cycle; single-cycle pulse
- id_stall_req  in  1  ID load-use hazard request
- jump_i  in  1  EX taken branch/jump; same pulse that flushes if_id/id_ex
- if_grant  out  1  memory port owned by IF
- mem_grant  out  1  memory port owned by MEM
- if_discard  out  1  the if_done word this cycle is stale and must not be latched
- stall_o  out  PIPE_NUM  stall vector; bit k = 1 means stage register k holds

Behaviour:
- Reset: state IDLE; if_grant = 0, mem_grant = 0, discard_r = 0, if_discard = 0, stall_o = 6'b000000.
- Reset mid-transfer abandons the transfer. Any later if_done/mem_done is ignored until a new grant is issued.
- FSM states: IDLE, IF_BUSY, MEM_BUSY. Grants are registered outputs: if_grant = (state == IF_BUSY), mem_grant = (state == MEM_BUSY).
- IDLE transitions:
  - mem_req -> MEM_BUSY. MEM wins over IF when both are requested in the same cycle.
  - else if_req -> IF_BUSY.
  - else stay in IDLE.
- IF_BUSY: on if_done -> IDLE. mem_req never preempts an in-flight fetch.
- MEM_BUSY: on mem_done -> IDLE.
- Grant latency: a request seen in IDLE at cycle t gives grant = 1 from t+1. Grant falls the cycle after done. At least one IDLE cycle separates consecutive transfers.
- done pulses are ignored when their grant is not held.
- Squash tracking:
  - jump_i while state == IF_BUSY and no if_done this cycle sets discard_r.
  - On if_done with discard_r = 1: if_discard = 1 and discard_r clears.
  - jump_i in the same cycle as if_done: if_discard = 1 that cycle and discard_r is not set.
  - jump_i in IDLE or MEM_BUSY has no effect on discard_r.
- if_discard is combinational: if_done & if_grant & (discard_r | jump_i).
- Stall requests (combinational, from current state and inputs):
  - s_if = if_req & ~(if_done & if_grant & ~if_discard)
  - s_id = id_stall_req
  - s_mem = mem_req & ~(mem_done & mem_grant)
- Stall vector (highest request wins; vector is always thermometer-coded with contiguous low bits):
  - s_mem -> 6'b011111
  - else s_id -> 6'b000111
  - else s_if -> 6'b000011
  - else 6'b000000
- Stall-vector boundaries:
  - The done cycle itself is not stalled, so the stage captures the data that cycle.
  - A discarded fetch keeps s_if asserted; IF re-requests at the redirected PC.
- jump_i while s_mem = 1: the stall vector is unchanged. Stage registers apply their own flush-over-stall priority.
- Load-use bubble: id_stall_req gives stall[2] = 1 and stall[3] = 0, so id_ex inserts exactly one bubble per requested cycle.

Test Plan:
- Reset for 2 cycles, then idle inputs -> stall_o = 000000, both grants 0. Assert rst during MEM_BUSY -> next cycle state IDLE, mem_grant = 0.
- if_req = 1 at t0, if_done at t3 -> if_grant = 1 at t1..t3 and 0 at t4; stall_o = 000011 at t0..t2 and 000000 at t3.
- if_req and mem_req both rise at t0 -> mem_grant at t1. mem_done at t2 -> IDLE at t3, if_grant at t4. stall_o = 011111 until t2, then 000011 until if_done.
- Fetch in IF_BUSY, jump_i at t2, if_done at t4 -> if_discard = 1 at t4, stall_o stays 000011 at t4, discard_r = 0 at t5.
- jump_i coincident with if_done -> if_discard = 1 that cycle, discard_r remains 0. Next fetch completes with if_discard = 0.
- id_stall_req pulsed 1 cycle with no other requests -> stall_o = 000111 for that single cycle. With mem_req also active -> 011111.
